hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's fixed 2-operand forwarding logic.
- Sits beside the ID/EXE pipeline registers of the filter processor and generates per-operand forwarding selects for N_SRC source operands (MEM > WB priority).
- Adds load-use stall detection and a per-register scoreboard for multi-cycle (MAC/multiply) results, with stall/bubble control and a saturating stall-cycle counter.

Parameters:
- REG_AW, 4: register address width; 2**REG_AW architectural registers.
- N_SRC, 3: source operands per instruction (A, B, store-data).
- MC_LAT, 3: cycles from multi-cycle issue until its result is forwardable from MEM; 1..15.
- ZERO_HARD, 0: when 1, register 0 is never forwarded, scoreboarded or stalled on.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID stage holds a valid instruction
- id_src  in  N_SRC*REG_AW  ID source addresses, operand i at [i*REG_AW +: REG_AW]
- id_re  in  N_SRC  ID source read enables
- id_dst  in  REG_AW  ID destination
- id_we  in  1  ID writes a register
- id_mc  in  1  ID is a multi-cycle op
- ex_src  in  N_SRC*REG_AW  EXE source addresses
- ex_re  in  N_SRC  EXE read enables
- ex_dst  in  REG_AW  EXE destination
- ex_we  in  1  EXE writes a register
- ex_load  in  1  EXE is a memory load
- mem_dst  in  REG_AW  MEM destination
- mem_we  in  1  MEM writes a register
- wb_dst  in  REG_AW  WB destination
- wb_we  in  1  WB writes a register
- flush  in  1  ID instruction is being squashed this cycle
- fwd_sel  out  2*N_SRC  per operand: 00 regfile, 01 MEM, 10 WB; 11 never driven
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EXE
- mc_busy  out  1  multi-cycle unit occupied
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Forwarding, combinational, per operand i: if ex_re[i] && mem_we && ex_src_i==mem_dst -> 01; else if ex_re[i] && wb_we && ex_src_i==wb_dst -> 10; else 00. With ZERO_HARD=1 an address of 0 always yields 00.
- Load-use hazard (lu): id_valid && ex_load && ex_we && some i with id_re[i] && id_src_i==ex_dst.
- Scoreboard: one 4-bit down-counter sb[r] per register, plus unit counter uc.
- Issue event: id_valid && id_mc && !stall && !flush. It loads uc=MC_LAT and, if id_we, sb[id_dst]=MC_LAT.
- Otherwise every nonzero counter decrements by 1 per cycle. Issue has priority over decrement on the same register.
- Multi-cycle hazard (mh): id_valid && (RAW: some enabled id_src_i with sb!=0; or WAW: id_we && sb[id_dst]!=0; or structural: id_mc && uc!=0).
- stall = bubble = (lu || mh) && !flush && !rst.
- mc_busy = (uc!=0).
- Flush squashes only ID. Scoreboard and uc keep counting, because the issued op is already in flight.
- State machine, registered state st:
  - RUN -> STALL_LD on lu.
  - RUN -> STALL_MC on mh && !lu.
  - STALL_LD -> RUN next cycle. lu cannot persist, since the load has advanced.
  - STALL_MC -> RUN when mh clears.
  - Any state -> RUN on flush.
  - st is observable only through stall_cnt; it must agree with stall for verification.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Reset (asynchronous): all sb, uc, stall_cnt = 0; st=RUN; stall=bubble=mc_busy=0; fwd_sel is driven by its inputs.
- Reset mid-stall releases the stall immediately.
- Simultaneous MEM and WB match on the same operand: MEM wins, because it holds the newer value.

Decomposition:
- Shared package: state encoding (RUN, STALL_LD, STALL_MC) and fwd_sel codes (FWD_RF=00, FWD_MEM=01, FWD_WB=10), reused by the datapath mux.
- Natural sub-module: hfu_scoreboard, which holds the sb array, uc, and RAW/WAW/structural hazard compare. The top level keeps forwarding, lu, the FSM and stall_cnt.

Test Plan:
- ex_src_0=3, ex_re=001, mem_dst=3, mem_we=1, wb_dst=3, wb_we=1 -> fwd_sel[1:0]=01. Same with mem_we=0 -> 10.
- ex_load=1, ex_we=1, ex_dst=5; ID reads R5 -> stall=bubble=1 for exactly 1 cycle, stall_cnt 0->1.
- Issue mc op with id_dst=7, MC_LAT=3; next instruction reads R7 -> stall 3 cycles, then 0; mc_busy high for 3 cycles.
- Back-to-back mc ops with different destinations -> second stalls until uc=0 (structural). An mc op writing a busy register also stalls (WAW).
- ZERO_HARD=1: ex_src_0=0 matching mem_dst=0 with mem_we=1 -> fwd_sel=00. A load to R0 with ID reading R0 -> no stall.
- Assert rst during an mc stall -> stall=0 immediately, all counters 0. Assert flush during a load-use stall -> stall=0 that cycle, and stall_cnt does not increment.

Source files
------------

// File: rtl/hfu_pkg.sv
// Shared encodings for the hazard/forwarding unit: control FSM states and
// forwarding-mux select codes, also used by the EXE operand muxes.
package hfu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LD = 2'd1,
    STALL_MC = 2'd2
  } hfu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Width of each scoreboard down-counter; bounds the multi-cycle latency to 15.
  localparam int SB_W = 4;

endpackage

// File: rtl/hfu_scoreboard.sv
// Per-register scoreboard for multi-cycle results plus the unit-busy counter,
// and the RAW / WAW / structural hazard detection against the ID instruction.
module hfu_scoreboard
  import hfu_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int N_SRC     = 3,
  parameter int MC_LAT    = 3,
  parameter int ZERO_HARD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [N_SRC*REG_AW-1:0] id_src,
  input  logic [N_SRC-1:0]        id_re,
  input  logic [REG_AW-1:0]       id_dst,
  input  logic                    id_we,
  input  logic                    id_mc,
  input  logic                    issue,
  output logic                    mh,
  output logic                    mc_busy
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [SB_W-1:0] LAT = SB_W'(MC_LAT);

  logic [SB_W-1:0] sb_q [NREG];
  logic [SB_W-1:0] sb_d [NREG];
  logic [SB_W-1:0] uc_q, uc_d;
  logic            dst_track;
  logic            raw;

  // A hard-wired R0 is never loaded, so its counter stays zero and never hazards.
  assign dst_track = id_we && !((ZERO_HARD != 0) && (id_dst == '0));

  always_comb begin
    uc_d = (uc_q != '0) ? uc_q - 1'b1 : uc_q;
    if (issue) uc_d = LAT;
    for (int r = 0; r < NREG; r++) begin
      sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - 1'b1 : sb_q[r];
      if (issue && dst_track && (id_dst == REG_AW'(r))) sb_d[r] = LAT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uc_q <= '0;
      for (int r = 0; r < NREG; r++) sb_q[r] <= '0;
    end else begin
      uc_q <= uc_d;
      for (int r = 0; r < NREG; r++) sb_q[r] <= sb_d[r];
    end
  end

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (id_re[i] && (sb_q[id_src[i*REG_AW +: REG_AW]] != '0)) raw = 1'b1;
    end
  end

  assign mh      = id_valid && (raw || (id_we && (sb_q[id_dst] != '0)) || (id_mc && (uc_q != '0)));
  assign mc_busy = (uc_q != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects, load-use / multi-cycle stall generation and
// a saturating stall-cycle counter for the ID/EXE boundary.
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int REG_AW    = 4,
  parameter int N_SRC     = 3,
  parameter int MC_LAT    = 3,
  parameter int ZERO_HARD = 0,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [N_SRC*REG_AW-1:0] id_src,
  input  logic [N_SRC-1:0]        id_re,
  input  logic [REG_AW-1:0]       id_dst,
  input  logic                    id_we,
  input  logic                    id_mc,
  input  logic [N_SRC*REG_AW-1:0] ex_src,
  input  logic [N_SRC-1:0]        ex_re,
  input  logic [REG_AW-1:0]       ex_dst,
  input  logic                    ex_we,
  input  logic                    ex_load,
  input  logic [REG_AW-1:0]       mem_dst,
  input  logic                    mem_we,
  input  logic [REG_AW-1:0]       wb_dst,
  input  logic                    wb_we,
  input  logic                    flush,
  output logic [2*N_SRC-1:0]      fwd_sel,
  output logic                    stall,
  output logic                    bubble,
  output logic                    mc_busy,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic [N_SRC-1:0] lu_hit;
  logic             lu, mh, issue;
  hfu_state_e       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_op
      logic [REG_AW-1:0] ex_a, id_a;
      logic              ex_zero, id_zero;
      assign ex_a    = ex_src[gi*REG_AW +: REG_AW];
      assign id_a    = id_src[gi*REG_AW +: REG_AW];
      assign ex_zero = (ZERO_HARD != 0) && (ex_a == '0);
      assign id_zero = (ZERO_HARD != 0) && (id_a == '0);
      // MEM is checked first: it holds the younger write to the same register.
      assign fwd_sel[2*gi +: 2] =
        (ex_zero || !ex_re[gi])         ? FWD_RF  :
        (mem_we && (ex_a == mem_dst))   ? FWD_MEM :
        (wb_we && (ex_a == wb_dst))     ? FWD_WB  : FWD_RF;
      assign lu_hit[gi] = id_re[gi] && !id_zero && (id_a == ex_dst);
    end
  endgenerate

  assign lu      = id_valid && ex_load && ex_we && (|lu_hit);
  assign stall   = (lu || mh) && !flush && !rst;
  assign bubble  = stall;
  assign issue   = id_valid && id_mc && !stall && !flush;

  hfu_scoreboard #(
    .REG_AW   (REG_AW),
    .N_SRC    (N_SRC),
    .MC_LAT   (MC_LAT),
    .ZERO_HARD(ZERO_HARD)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .id_valid(id_valid),
    .id_src  (id_src),
    .id_re   (id_re),
    .id_dst  (id_dst),
    .id_we   (id_we),
    .id_mc   (id_mc),
    .issue   (issue),
    .mh      (mh),
    .mc_busy (mc_busy)
  );

  always_comb begin
    st_d = st_q;
    case (st_q)
      RUN:      if (lu) st_d = STALL_LD; else if (mh) st_d = STALL_MC;
      STALL_LD: st_d = RUN;
      STALL_MC: if (!mh) st_d = RUN;
      default:  st_d = RUN;
    endcase
    if (flush) st_d = RUN;
  end

  assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= RUN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: a default unit and a ZERO_HARD=1 / 2-bit-counter unit share stimulus.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_we, id_mc, ex_we, ex_load, mem_we, wb_we, flush;
  logic [11:0] id_src, ex_src;
  logic [2:0]  id_re, ex_re;
  logic [3:0]  id_dst, ex_dst, mem_dst, wb_dst;

  logic [5:0]  fwd0, fwd1;
  logic        stall0, bubble0, busy0, stall1, bubble1, busy1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_re(id_re),
    .id_dst(id_dst), .id_we(id_we), .id_mc(id_mc), .ex_src(ex_src), .ex_re(ex_re),
    .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load), .mem_dst(mem_dst), .mem_we(mem_we),
    .wb_dst(wb_dst), .wb_we(wb_we), .flush(flush), .fwd_sel(fwd0), .stall(stall0),
    .bubble(bubble0), .mc_busy(busy0), .stall_cnt(cnt0)
  );

  hazard_forward_unit #(.ZERO_HARD(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_re(id_re),
    .id_dst(id_dst), .id_we(id_we), .id_mc(id_mc), .ex_src(ex_src), .ex_re(ex_re),
    .ex_dst(ex_dst), .ex_we(ex_we), .ex_load(ex_load), .mem_dst(mem_dst), .mem_we(mem_we),
    .wb_dst(wb_dst), .wb_we(wb_we), .flush(flush), .fwd_sel(fwd1), .stall(stall1),
    .bubble(bubble1), .mc_busy(busy1), .stall_cnt(cnt1)
  );

  function automatic logic [11:0] pk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    id_valid = 1'b1; id_we = 1'b0; id_mc = 1'b0; id_dst = 4'd0;
    id_src = pk(4'd5, 4'd0, 4'd0); id_re = 3'b001;
    ex_load = 1'b1; ex_we = 1'b1; ex_dst = 4'd5;
    ex_src = pk(4'd3, 4'd0, 4'd0); ex_re = 3'b001;
    mem_dst = 4'd3; mem_we = 1'b1; wb_dst = 4'd3; wb_we = 1'b1;
    #2;
    $display("step: reset with load-use present");
    chk("rst_stall", stall0, 1'b0);
    chk("rst_bubble", bubble0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_cnt", cnt0, 16'd0);
    chk("rst_fwd", fwd0, 6'h01);

    @(posedge clk); #1;
    rst = 1'b0; id_valid = 1'b0;
    #1;
    $display("step: forwarding priority");
    chk("fwd_mem_over_wb", fwd0, 6'h01);
    mem_we = 1'b0; #1;
    chk("fwd_wb", fwd0, 6'h02);
    ex_re = 3'b111; ex_src = pk(4'd3, 4'd3, 4'd3); mem_we = 1'b1; #1;
    chk("fwd_all_mem", fwd0, 6'h15);
    ex_src = pk(4'd3, 4'd4, 4'd3); wb_dst = 4'd4; #1;
    chk("fwd_mixed", fwd0, 6'h19);
    ex_re = 3'b000; mem_we = 1'b0; wb_we = 1'b0; #1;
    chk("fwd_disabled", fwd0, 6'h00);

    $display("step: load-use");
    id_valid = 1'b1; #1;
    chk("lu_stall", stall0, 1'b1);
    chk("lu_bubble", bubble0, 1'b1);
    chk("lu_cnt_pre", cnt0, 16'd0);
    tick();
    chk("lu_cnt_post", cnt0, 16'd1);
    chk("lu_cnt1_post", cnt1, 2'd1);
    ex_load = 1'b0; ex_we = 1'b0; #1;
    chk("lu_release", stall0, 1'b0);
    tick();
    chk("lu_cnt_hold", cnt0, 16'd1);

    $display("step: multi-cycle RAW");
    id_src = pk(4'd0, 4'd0, 4'd0); id_re = 3'b000; id_mc = 1'b1; id_we = 1'b1; id_dst = 4'd7; #1;
    chk("mc_issue_nostall", stall0, 1'b0);
    chk("mc_issue_busy", busy0, 1'b0);
    tick();
    id_mc = 1'b0; id_we = 1'b0; id_re = 3'b001; id_src = pk(4'd7, 4'd0, 4'd0); #1;
    for (int k = 0; k < 3; k++) begin
      chk("raw_stall", stall0, 1'b1);
      chk("raw_busy", busy0, 1'b1);
      tick();
    end
    chk("raw_release", stall0, 1'b0);
    chk("raw_busy_off", busy0, 1'b0);
    chk("raw_cnt", cnt0, 16'd4);
    chk("raw_cnt1_sat", cnt1, 2'd3);

    $display("step: structural and WAW");
    id_re = 3'b000; id_mc = 1'b1; id_we = 1'b1; id_dst = 4'd8; #1;
    chk("st_first_issue", stall0, 1'b0);
    tick();
    id_dst = 4'd9; #1;
    for (int k = 0; k < 3; k++) begin
      chk("st_stall", stall0, 1'b1);
      tick();
    end
    chk("st_release", stall0, 1'b0);
    chk("st_busy_off", busy0, 1'b0);
    tick();
    chk("st_second_busy", busy0, 1'b1);
    chk("st_cnt", cnt0, 16'd7);
    chk("st_cnt1_sat", cnt1, 2'd3);
    id_mc = 1'b0; #1;
    chk("waw_stall", stall0, 1'b1);
    id_valid = 1'b0; #1;
    chk("waw_invalid", stall0, 1'b0);
    tick(); tick(); tick();
    chk("waw_drain_busy", busy0, 1'b0);
    chk("waw_cnt", cnt0, 16'd7);

    $display("step: register zero");
    id_we = 1'b0;
    ex_src = pk(4'd0, 4'd0, 4'd0); ex_re = 3'b001; mem_dst = 4'd0; mem_we = 1'b1; #1;
    chk("z_fwd_soft", fwd0, 6'h01);
    chk("z_fwd_hard", fwd1, 6'h00);
    ex_load = 1'b1; ex_we = 1'b1; ex_dst = 4'd0;
    id_valid = 1'b1; id_src = pk(4'd0, 4'd0, 4'd0); id_re = 3'b001; #1;
    chk("z_lu_soft", stall0, 1'b1);
    chk("z_lu_hard", stall1, 1'b0);
    id_valid = 1'b0; ex_load = 1'b0; ex_we = 1'b0; mem_we = 1'b0; ex_re = 3'b000; #1;

    $display("step: reset during mc stall");
    id_valid = 1'b1; id_mc = 1'b1; id_we = 1'b1; id_dst = 4'd7; id_re = 3'b000; #1;
    chk("rs_issue", stall0, 1'b0);
    tick();
    id_mc = 1'b0; id_we = 1'b0; id_re = 3'b001; id_src = pk(4'd7, 4'd0, 4'd0); #1;
    chk("rs_stall", stall0, 1'b1);
    tick();
    chk("rs_stall2", stall0, 1'b1);
    chk("rs_cnt_pre", cnt0, 16'd8);
    rst = 1'b1; #1;
    chk("rs_stall_off", stall0, 1'b0);
    chk("rs_bubble_off", bubble0, 1'b0);
    chk("rs_busy_off", busy0, 1'b0);
    chk("rs_cnt0", cnt0, 16'd0);
    chk("rs_cnt1", cnt1, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("rs_sb_cleared", stall0, 1'b0);
    tick();
    chk("rs_cnt_after", cnt0, 16'd0);

    $display("step: flush");
    ex_load = 1'b1; ex_we = 1'b1; ex_dst = 4'd5; id_src = pk(4'd5, 4'd0, 4'd0); #1;
    chk("fl_pre_stall", stall0, 1'b1);
    flush = 1'b1; #1;
    chk("fl_stall", stall0, 1'b0);
    chk("fl_bubble", bubble0, 1'b0);
    tick();
    chk("fl_cnt", cnt0, 16'd0);
    ex_load = 1'b0; ex_we = 1'b0; id_re = 3'b000; id_mc = 1'b1; id_we = 1'b1; id_dst = 4'd2;
    tick();
    chk("fl_no_issue", busy0, 1'b0);
    flush = 1'b0; id_valid = 1'b0; id_mc = 1'b0; id_we = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
